// File: rtl/fetch_redirect_ctrl.sv
// ============================================================================
//  Module      : fetch_redirect_ctrl
//  Description : Owns the fetch PC, sequences imem req/ack, drains in-flight
//                requests on redirect and skids data returned during a stall.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

module fetch_redirect_ctrl #(
    parameter int                  PC_WIDTH = `PC_WIDTH,
    parameter int                  DWIDTH   = `DWIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  PC_STEP  = 4
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_change_pc,
    input  logic [PC_WIDTH-1:0] i_target_pc,
    input  logic                i_stall,
    input  logic                i_imem_ack,
    input  logic [DWIDTH-1:0]   i_imem_rdata,
    output logic                o_imem_req,
    output logic [PC_WIDTH-1:0] o_imem_addr,
    output logic [DWIDTH-1:0]   o_instr,
    output logic [PC_WIDTH-1:0] o_instr_pc,
    output logic                o_instr_valid,
    output logic                o_flush
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_REQ   = 2'd1;
    localparam logic [1:0] c_HELD  = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    localparam logic [PC_WIDTH-1:0] c_STEP = PC_WIDTH'(PC_STEP);

    logic [1:0]          state_q,    state_d;
    logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0] pend_pc_q,  pend_pc_d;
    logic [DWIDTH-1:0]   skid_q,     skid_d;
    logic [PC_WIDTH-1:0] skid_pc_q,  skid_pc_d;
    logic [DWIDTH-1:0]   instr_q,    instr_d;
    logic [PC_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                valid_q,    valid_d;
    logic                flush_q,    flush_d;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= c_IDLE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= '0;
            skid_q     <= '0;
            skid_pc_q  <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            flush_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
            skid_q     <= skid_d;
            skid_pc_q  <= skid_pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            flush_q    <= flush_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  state_d = c_REQ;
            c_REQ: begin
                if (i_change_pc)
                    state_d = i_imem_ack ? c_REQ : c_DRAIN;
                else if (i_imem_ack && i_stall)
                    state_d = c_HELD;
            end
            c_HELD: begin
                if (i_change_pc || !i_stall)
                    state_d = c_REQ;
            end
            c_DRAIN: begin
                if (i_imem_ack)
                    state_d = c_REQ;
            end
            default: state_d = c_IDLE;
        endcase
    end

    // Datapath next-state; redirect is always tested first so it beats stall.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        skid_d     = skid_q;
        skid_pc_d  = skid_pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        flush_d    = 1'b0;
        case (state_q)
            c_REQ: begin
                if (i_change_pc) begin
                    flush_d = 1'b1;
                    valid_d = 1'b0;
                    if (i_imem_ack)
                        fetch_pc_d = i_target_pc;
                    else
                        pend_pc_d = i_target_pc;
                end else if (i_imem_ack) begin
                    fetch_pc_d = fetch_pc_q + c_STEP;
                    if (i_stall) begin
                        skid_d    = i_imem_rdata;
                        skid_pc_d = fetch_pc_q;
                    end else begin
                        instr_d    = i_imem_rdata;
                        instr_pc_d = fetch_pc_q;
                        valid_d    = 1'b1;
                    end
                end else if (!i_stall) begin
                    valid_d = 1'b0;
                end
            end
            c_HELD: begin
                if (i_change_pc) begin
                    flush_d    = 1'b1;
                    fetch_pc_d = i_target_pc;
                    valid_d    = 1'b0;
                end else if (!i_stall) begin
                    instr_d    = skid_q;
                    instr_pc_d = skid_pc_q;
                    valid_d    = 1'b1;
                end
            end
            c_DRAIN: begin
                valid_d = 1'b0;
                if (i_change_pc) begin
                    flush_d   = 1'b1;
                    pend_pc_d = i_target_pc;
                end
                if (i_imem_ack)
                    fetch_pc_d = i_change_pc ? i_target_pc : pend_pc_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_imem_req    = (state_q == c_REQ) || (state_q == c_DRAIN);
        o_imem_addr   = fetch_pc_q;
        o_instr       = instr_q;
        o_instr_pc    = instr_pc_q;
        o_instr_valid = valid_q;
        o_flush       = flush_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_redirect_ctrl.sv
// ============================================================================
//  Module      : tb_fetch_redirect_ctrl
//  Description : Directed vector table plus randomized run against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        chg;
    logic [31:0] tgt;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        valid;
    logic        flush;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl #(
        .PC_WIDTH (32),
        .DWIDTH   (32),
        .RESET_PC (32'h0),
        .PC_STEP  (4)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_change_pc   (chg),
        .i_target_pc   (tgt),
        .i_stall       (stall),
        .i_imem_ack    (ack),
        .i_imem_rdata  (rdata),
        .o_imem_req    (req),
        .o_imem_addr   (addr),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .o_instr_valid (valid),
        .o_flush       (flush)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, chg, stall, ack;
        logic [31:0] tgt, rdata;
        logic        chk_comb;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        logic        e_flush;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic r, logic c, logic [31:0] t, logic s, logic a, logic [31:0] d,
                                logic cc, logic er, logic [31:0] ea,
                                logic ev, logic [31:0] ep, logic [31:0] ei, logic ef);
        vec_t v;
        v.rst = r; v.chg = c; v.tgt = t; v.stall = s; v.ack = a; v.rdata = d;
        v.chk_comb = cc; v.e_req = er; v.e_addr = ea;
        v.e_valid = ev; v.e_pc = ep; v.e_instr = ei; v.e_flush = ef;
        return v;
    endfunction

    // Behavioural reference: a handful of flags instead of an explicit state code.
    logic        m_started, m_have_skid, m_draining;
    logic [31:0] m_pc, m_pend, m_skid, m_skid_pc;
    logic [31:0] m_instr, m_ipc;
    logic        m_valid, m_flush;

    function automatic logic m_req();
        return m_started && !m_have_skid;
    endfunction

    task automatic m_reset();
        m_started = 0; m_have_skid = 0; m_draining = 0;
        m_pc = 0; m_pend = 0; m_skid = 0; m_skid_pc = 0;
        m_instr = 0; m_ipc = 0; m_valid = 0; m_flush = 0;
    endtask

    task automatic m_step(input logic r, input logic c, input logic [31:0] t,
                          input logic s, input logic a, input logic [31:0] d);
        if (!r) begin
            m_reset();
            return;
        end
        m_flush = m_started && c;
        if (!m_started) begin
            m_started = 1;
        end else if (m_have_skid) begin
            if (c) begin
                m_have_skid = 0; m_pc = t; m_valid = 0;
            end else if (!s) begin
                m_have_skid = 0; m_instr = m_skid; m_ipc = m_skid_pc; m_valid = 1;
            end
        end else if (m_draining) begin
            m_valid = 0;
            if (c) m_pend = t;
            if (a) begin
                m_pc = m_pend;
                m_draining = 0;
            end
        end else begin
            if (c) begin
                m_valid = 0;
                if (a) m_pc = t;
                else begin m_pend = t; m_draining = 1; end
            end else if (a) begin
                if (s) begin
                    m_skid = d; m_skid_pc = m_pc; m_have_skid = 1;
                end else begin
                    m_instr = d; m_ipc = m_pc; m_valid = 1;
                end
                m_pc = m_pc + 32'd4;
            end else if (!s) begin
                m_valid = 0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic c, input logic [31:0] t,
                         input logic s, input logic a, input logic [31:0] d);
        @(negedge clk);
        rst = r; chg = c; tgt = t; stall = s; ack = a; rdata = d;
        #1;
    endtask

    initial begin
        rst = 0; chg = 0; tgt = 0; stall = 0; ack = 0; rdata = 0;

        //        rst chg tgt           stl ack rdata          cc  req addr          val pc            instr         flush
        vt.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        32'h0,  0));
        vt.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        32'h0,  0));
        vt.push_back(mk(1, 0, 32'h0,        0, 1, 32'h11,       1, 1, 32'h0,         1, 32'h0,        32'h11, 0));
        vt.push_back(mk(1, 0, 32'h0,        0, 1, 32'h22,       1, 1, 32'h4,         1, 32'h4,        32'h22, 0));
        vt.push_back(mk(1, 0, 32'h0,        0, 1, 32'h33,       1, 1, 32'h8,         1, 32'h8,        32'h33, 0));
        vt.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'hC,         0, 32'h8,        32'h33, 0));
        vt.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'hC,         0, 32'h8,        32'h33, 0));
        vt.push_back(mk(1, 0, 32'h0,        0, 1, 32'h44,       1, 1, 32'hC,         1, 32'hC,        32'h44, 0));
        vt.push_back(mk(1, 0, 32'h0,        1, 1, 32'h55,       1, 1, 32'h10,        1, 32'hC,        32'h44, 0));
        vt.push_back(mk(1, 0, 32'h0,        1, 1, 32'hEE,       1, 0, 32'h0,         1, 32'hC,        32'h44, 0));
        vt.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 0, 32'h0,         1, 32'hC,        32'h44, 0));
        vt.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h10,       32'h55, 0));
        vt.push_back(mk(1, 1, 32'h100,      0, 1, 32'h66,       1, 1, 32'h14,        0, 32'h10,       32'h55, 1));
        vt.push_back(mk(1, 0, 32'h0,        0, 1, 32'h77,       1, 1, 32'h100,       1, 32'h100,      32'h77, 0));
        vt.push_back(mk(1, 1, 32'h200,      0, 0, 32'h0,        1, 1, 32'h104,       0, 32'h100,      32'h77, 1));
        vt.push_back(mk(1, 1, 32'h300,      1, 0, 32'h0,        1, 1, 32'h104,       0, 32'h100,      32'h77, 1));
        vt.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 1, 32'h104,       0, 32'h100,      32'h77, 0));
        vt.push_back(mk(1, 0, 32'h0,        0, 1, 32'h88,       1, 1, 32'h104,       0, 32'h100,      32'h77, 0));
        vt.push_back(mk(1, 0, 32'h0,        1, 1, 32'h99,       1, 1, 32'h300,       0, 32'h100,      32'h77, 0));
        vt.push_back(mk(1, 1, 32'h40,       1, 0, 32'h0,        1, 0, 32'h0,         0, 32'h100,      32'h77, 1));
        vt.push_back(mk(1, 1, 32'h500,      0, 0, 32'h0,        1, 1, 32'h40,        0, 32'h100,      32'h77, 1));
        vt.push_back(mk(0, 0, 32'h0,        0, 1, 32'hBB,       1, 1, 32'h40,        0, 32'h0,        32'h0,  0));
        vt.push_back(mk(1, 0, 32'h0,        0, 1, 32'hCC,       1, 0, 32'h0,         0, 32'h0,        32'h0,  0));
        vt.push_back(mk(1, 0, 32'h0,        0, 1, 32'h12,       1, 1, 32'h0,         1, 32'h0,        32'h12, 0));
        vt.push_back(mk(1, 1, 32'hFFFFFFFC, 0, 1, 32'h0,        1, 1, 32'h4,         0, 32'h0,        32'h12, 1));
        vt.push_back(mk(1, 0, 32'h0,        0, 1, 32'hAB,       1, 1, 32'hFFFFFFFC,  1, 32'hFFFFFFFC, 32'hAB, 0));
        vt.push_back(mk(1, 0, 32'h0,        0, 1, 32'hCD,       1, 1, 32'h0,         1, 32'h0,        32'hCD, 0));

        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].rst, vt[i].chg, vt[i].tgt, vt[i].stall, vt[i].ack, vt[i].rdata);
            if (vt[i].chk_comb) begin
                check($sformatf("v%0d req", i), {31'b0, req}, {31'b0, vt[i].e_req});
                if (vt[i].e_req)
                    check($sformatf("v%0d addr", i), addr, vt[i].e_addr);
            end
            @(posedge clk); #1;
            check($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, vt[i].e_valid});
            check($sformatf("v%0d instr_pc", i), instr_pc, vt[i].e_pc);
            check($sformatf("v%0d instr", i), instr, vt[i].e_instr);
            check($sformatf("v%0d flush", i), {31'b0, flush}, {31'b0, vt[i].e_flush});
        end

        // Randomized run against the reference model, starting from reset.
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        r, ch, s, a;
            logic [31:0] t, d;
            r  = ($urandom_range(0, 99) != 0);
            ch = ($urandom_range(0, 7) == 0);
            s  = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 1) == 0);
            t  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFF_FFFC);
            d  = $urandom();
            drive(r, ch, t, s, a, d);
            check("rnd req", {31'b0, req}, {31'b0, m_req()});
            if (m_req())
                check("rnd addr", addr, m_pc);
            @(posedge clk); #1;
            m_step(r, ch, t, s, a, d);
            check("rnd valid", {31'b0, valid}, {31'b0, m_valid});
            check("rnd flush", {31'b0, flush}, {31'b0, m_flush});
            if (m_valid) begin
                check("rnd instr", instr, m_instr);
                check("rnd instr_pc", instr_pc, m_ipc);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
